// File: rtl/cpumem_arbiter_if.sv
// Bundle between the CPU/loader requesters, the arbiter and the single-port CPU memory.
// The arbiter takes the slave view; the requesters and memory together form the master view.
interface cpumem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              req0, req1;
  logic              we0, we1;
  logic              lock0, lock1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              mem_readwrite;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_readwrite, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_readwrite, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cpumem_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing the 2048x8 CPU memory between CPU and loader.
// Optional grant/conflict statistics are built when CPUMEM_ARB_STATS_EN is defined.
module cpumem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic clk,
  input  logic reset,
  cpumem_arbiter_if.slave bus
`ifdef CPUMEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_gnt0,
  output logic [15:0] stat_gnt1,
  output logic [15:0] stat_conflict
`endif
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        last_reg, last_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [1:0]  req, we, lock, gnt, owner_oh;
  logic        gidx;
  logic        rvalid_reg [2];

  logic              mem_rw_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;

  assign req  = {bus.req1, bus.req0};
  assign we   = {bus.we1, bus.we0};
  assign lock = {bus.lock1, bus.lock0};

  always_comb begin
    gnt        = 2'b00;
    gidx       = 1'b0;
    state_next = state_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    owner_oh   = owner_reg ? 2'b10 : 2'b01;
    if (!reset) begin
      if (state_reg == ST_LOCKED && (req & owner_oh) != 2'b00) begin
        // A full burst yields to a waiting contender; otherwise the owner keeps the memory.
        if (cnt_reg == MAX_CNT && (req & ~owner_oh) != 2'b00)
          gnt = ~owner_oh;
        else
          gnt = owner_oh;
      end else if (req == 2'b11) begin
        gnt = last_reg ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end

      gidx = gnt[1];
      if (gnt != 2'b00) begin
        last_next = gidx;
        if (state_reg == ST_UNLOCKED || gidx != owner_reg) begin
          // Non-owner grant while locked: filler cycle if the owner is idle, else a hand-over.
          if (state_reg == ST_UNLOCKED || req[owner_reg]) begin
            if (lock[gidx]) begin
              state_next = ST_LOCKED;
              owner_next = gidx;
              cnt_next   = 8'd1;
            end else begin
              state_next = ST_UNLOCKED;
              cnt_next   = 8'd0;
            end
          end
        end else if (!lock[gidx]) begin
          state_next = ST_UNLOCKED;
          cnt_next   = 8'd0;
        end else if (cnt_reg != MAX_CNT) begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_UNLOCKED;
      owner_reg <= 1'b0;
      cnt_reg   <= 8'd0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    mem_rw_next    = 1'b1;
    mem_addr_next  = '0;
    mem_wdata_next = '0;
    if (gnt[0]) begin
      mem_rw_next    = ~we[0];
      mem_addr_next  = bus.addr0;
      mem_wdata_next = bus.wdata0;
    end else if (gnt[1]) begin
      mem_rw_next    = ~we[1];
      mem_addr_next  = bus.addr1;
      mem_wdata_next = bus.wdata1;
    end
  end

  assign bus.mem_readwrite = mem_rw_next;
  assign bus.mem_addr      = mem_addr_next;
  assign bus.mem_wdata     = mem_wdata_next;
  assign bus.gnt0          = gnt[0];
  assign bus.gnt1          = gnt[1];
  assign bus.rdata         = bus.mem_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rvalid
      always_ff @(posedge clk) begin
        if (reset)
          rvalid_reg[gi] <= 1'b0;
        else
          rvalid_reg[gi] <= gnt[gi] & ~we[gi];
      end
    end
  endgenerate

  // A read issued just before reset must not report data during the reset cycle.
  assign bus.rvalid0 = rvalid_reg[0] & ~reset;
  assign bus.rvalid1 = rvalid_reg[1] & ~reset;

`ifdef CPUMEM_ARB_STATS_EN
  logic [15:0] stat_gnt_reg [2];
  logic [15:0] stat_conflict_reg;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_stat
      always_ff @(posedge clk) begin
        if (reset)
          stat_gnt_reg[gi] <= 16'd0;
        else if (gnt[gi] && stat_gnt_reg[gi] != 16'hFFFF)
          stat_gnt_reg[gi] <= stat_gnt_reg[gi] + 16'd1;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      stat_conflict_reg <= 16'd0;
    else if (req == 2'b11 && stat_conflict_reg != 16'hFFFF)
      stat_conflict_reg <= stat_conflict_reg + 16'd1;
  end

  assign stat_gnt0     = stat_gnt_reg[0];
  assign stat_gnt1     = stat_gnt_reg[1];
  assign stat_conflict = stat_conflict_reg;
`endif

endmodule
